ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 140 ++++++++++++++
 tb/tb_ifu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: one outstanding fetch feeding a small instruction buffer
module ifu #(
  parameter logic [63:0] PC_INIT = 64'h8000_0000,
  parameter int          DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [63:0]   PC_RST  = {PC_INIT[63:2], 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic          drop_q, drop_d;
  logic          req_valid_q, req_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [63:0]   pc_q [DEPTH];
  logic [63:0]   pc_d [DEPTH];

  logic          hs, push, pop;
  logic [CW-1:0] count_step;
  logic          unused_redirect_lsbs;

  // Redirect targets are word-aligned by dropping the low address bits.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign hs         = req_valid_q && imem_req_ready;
  assign push       = (state_q == S_WAIT) && imem_resp_valid && !drop_q;
  assign pop        = (count_q != '0) && inst_ready;
  assign count_step = count_q + CW'(push) - CW'(pop);

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = data_q[rd_ptr_q];
  assign inst_pc        = pc_q[rd_ptr_q];

  // Next-state: fetch FSM, buffer push/pop, with redirect overriding everything last.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    count_d    = count_step;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    data_d     = data_q;
    pc_d       = pc_q;

    if (hs) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
      req_pc_d   = fetch_pc_q;
    end
    if (push) begin
      data_d[wr_ptr_q] = imem_resp_data;
      pc_d[wr_ptr_q]   = req_pc_q;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A stale response retires the drop flag wherever the FSM is.
    if (drop_q && imem_resp_valid) begin
      drop_d = 1'b0;
    end

    case (state_q)
      S_IDLE: if (count_q < DEPTH_C) state_d = S_REQ;
      S_REQ:  if (hs) state_d = S_WAIT;
      S_WAIT: if (imem_resp_valid) state_d = (count_step < DEPTH_C) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      state_d    = S_REQ;
      // An older request is still in flight: its response must be swallowed.
      if (((state_q == S_WAIT) && !imem_resp_valid) || hs) begin
        drop_d = 1'b1;
      end
    end

    // No new request may issue while a dropped response is still owed.
    req_valid_d = (state_d == S_REQ) && !drop_d;
  end

  // State registers; reset parks in REQ with the request held low until the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= PC_RST;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      data_q      <= data_d;
      pc_q        <= pc_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - scoreboard testbench for ifu
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  ifu #(.PC_INIT(64'h8000_0000), .DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          auto_resp = 0;
  bit          outstanding = 0;
  bit          drop_next = 0;
  bit          last_hs = 0;
  logic [63:0] rsp_pc = '0;
  int          cycle = 0;
  int          last_hs_cycle = 0;
  int          hs_gap = 0;
  logic [63:0] head_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0073;
    if (a == 64'h8000_0004) return 32'h0000_0013;
    return a[31:0] ^ 32'h5a5a_0000;
  endfunction

  // One clock: model the memory/consumer against the current inputs, then advance.
  task automatic tick();
    bit          hs_now, rsp_now, pop_now;
    logic [63:0] hs_addr;
    ent_t        e;
    hs_now  = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    rsp_now = imem_resp_valid;
    pop_now = inst_valid && inst_ready;
    if (redirect_valid) begin
      exp_q.delete();
      drop_next   = hs_now || (outstanding && !rsp_now) || (drop_next && !rsp_now);
      outstanding = (outstanding && !rsp_now) || hs_now;
    end else begin
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", inst_pc, e.pc);
          check("pop_inst", {32'd0, inst}, {32'd0, e.ins});
        end
      end
      if (rsp_now && outstanding) begin
        if (drop_next) drop_next = 0;
        else exp_q.push_back('{pc: rsp_pc, ins: imem_resp_data});
        outstanding = 0;
      end
      if (hs_now) outstanding = 1;
    end
    if (hs_now) rsp_pc = hs_addr;
    @(posedge clk);
    #1;
    cycle++;
    last_hs = hs_now;
    if (hs_now) begin
      hs_gap        = cycle - last_hs_cycle;
      last_hs_cycle = cycle;
    end
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    if (auto_resp && hs_now) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(hs_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;

    // Reset state
    #12;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_inst", {32'd0, inst}, 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);

    // Reset release and in-order fetch
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    auto_resp      = 1;
    tick();
    check("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("first_req_addr", imem_req_addr, 64'h8000_0000);
    tick();
    check("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
    tick();
    check("second_req_addr", imem_req_addr, 64'h8000_0004);
    check("first_head_pc", inst_pc, 64'h8000_0000);
    check("first_head_inst", {32'd0, inst}, 64'h0010_0073);
    repeat (12) tick();
    check("throughput_gap", hs_gap, 64'd2);

    // Buffer fills to DEPTH with decode stalled
    inst_ready = 1'b0;
    repeat (12) tick();
    check("fill_no_req", {63'd0, imem_req_valid}, 64'd0);
    check("fill_entries", exp_q.size(), 64'd2);
    check("fill_inst_valid", {63'd0, inst_valid}, 64'd1);
    head_pc = (exp_q.size() != 0) ? exp_q[0].pc : 64'd0;
    repeat (3) tick();
    check("head_stable", inst_pc, head_pc);
    inst_ready = 1'b1;
    repeat (8) tick();

    // Redirect while waiting for a response
    auto_resp = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = last_hs;
    end
    check("redir_reach_wait", {63'd0, found}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1006;
    tick();
    check("redir_flush", {63'd0, inst_valid}, 64'd0);
    check("redir_hold_req", {63'd0, imem_req_valid}, 64'd0);
    tick();
    check("redir_hold_req2", {63'd0, imem_req_valid}, 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdead_beef;
    tick();
    check("redir_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("redir_req_addr", imem_req_addr, 64'h8000_1004);
    check("redir_empty", {63'd0, inst_valid}, 64'd0);
    auto_resp  = 1;
    inst_ready = 1'b0;
    tick();
    check("redir_empty_wait", {63'd0, inst_valid}, 64'd0);
    tick();
    check("redir_first_pc", inst_pc, 64'h8000_1004);
    inst_ready = 1'b1;
    repeat (8) tick();

    // Redirect coinciding with push and pop at count=1
    imem_req_ready = 1'b0;
    repeat (6) tick();
    check("drain_pre", exp_q.size(), 64'd0);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    tick();
    tick();
    auto_resp = 0;
    tick();
    check("pp_count1", exp_q.size(), 64'd1);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h2222_2222;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h8000_2000;
    inst_ready      = 1'b1;
    tick();
    check("pp_flush", {63'd0, inst_valid}, 64'd0);
    check("pp_req_addr", imem_req_addr, 64'h8000_2000);
    auto_resp = 1;
    repeat (10) tick();

    // Asynchronous reset in the middle of a fetch
    auto_resp = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = last_hs;
    end
    check("rst_reach_wait", {63'd0, found}, 64'd1);
    rst_n = 1'b0;
    #2;
    check("arst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("arst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("arst_inst", {32'd0, inst}, 64'd0);
    check("arst_inst_pc", inst_pc, 64'd0);
    exp_q.delete();
    outstanding = 0;
    drop_next   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hbad0_bad0;
    tick();
    check("arst_req_addr", imem_req_addr, 64'h8000_0000);
    check("arst_late_ignored", {63'd0, inst_valid}, 64'd0);
    auto_resp = 1;
    repeat (10) tick();

    imem_req_ready = 1'b0;
    repeat (8) tick();
    check("final_drain", exp_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
